// File: rtl/branch_predict_ctrl_if.sv
// Fetch/execute signal bundle between the pipeline and the branch predictor.
// The master side drives fetch and execute inputs; the slave side is the predictor.
interface branch_predict_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] pcF;
  logic [6:0]            opcodeF;
  logic [ADDR_WIDTH-1:0] pcTargetF;
  logic                  predictTakenF;
  logic [ADDR_WIDTH-1:0] predPCF;

  logic                  branchE;
  logic                  takenE;
  logic                  predTakenE;
  logic [ADDR_WIDTH-1:0] pcE;
  logic [ADDR_WIDTH-1:0] pcTargetE;
  logic [ADDR_WIDTH-1:0] pcPlus4E;
  logic                  redirectE;
  logic [ADDR_WIDTH-1:0] redirectPC;
  logic                  flushD;
  logic                  flushE;

  logic [CNT_WIDTH-1:0]  branchCount;
  logic [CNT_WIDTH-1:0]  mispredictCount;

  modport master (
    output pcF, opcodeF, pcTargetF,
    output branchE, takenE, predTakenE, pcE, pcTargetE, pcPlus4E,
    input  predictTakenF, predPCF, redirectE, redirectPC, flushD, flushE,
    input  branchCount, mispredictCount
  );

  modport slave (
    input  pcF, opcodeF, pcTargetF,
    input  branchE, takenE, predTakenE, pcE, pcTargetE, pcPlus4E,
    output predictTakenF, predPCF, redirectE, redirectPC, flushD, flushE,
    output branchCount, mispredictCount
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter branch predictor with execute-stage mispredict redirect
// and saturating branch/mispredict statistics.
module branch_predict_ctrl #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  branch_predict_ctrl_if.slave bp
);

  localparam int unsigned ENTRIES    = 1 << INDEX_BITS;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [1:0]  CTR_WNT    = 2'b01;
  localparam logic [1:0]  CTR_ST     = 2'b11;
  localparam logic [1:0]  CTR_SNT    = 2'b00;

  logic [ENTRIES-1:0][1:0] table_q, table_d;
  logic [CNT_WIDTH-1:0]    br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0]    mis_cnt_q, mis_cnt_d;

  logic [INDEX_BITS-1:0]   f_idx_c;
  logic [INDEX_BITS-1:0]   e_idx_c;
  logic                    update_c;
  logic                    mispredict_c;
  logic                    unused_pc_bits;

  assign f_idx_c = bp.pcF[INDEX_BITS+1:2];
  assign e_idx_c = bp.pcE[INDEX_BITS+1:2];

  // Gating with ~rst keeps an undefined branchE during reset from leaking out.
  assign update_c     = bp.branchE & ~stall & ~rst;
  assign mispredict_c = update_c & (bp.takenE ^ bp.predTakenE);

  assign bp.predictTakenF = ~rst & (bp.opcodeF == OPC_BRANCH) & table_q[f_idx_c][1];
  assign bp.predPCF       = bp.predictTakenF ? bp.pcTargetF : bp.pcF + ADDR_WIDTH'(4);

  assign bp.redirectE  = mispredict_c;
  assign bp.redirectPC = bp.takenE ? bp.pcTargetE : bp.pcPlus4E;
  assign bp.flushD     = mispredict_c;
  assign bp.flushE     = mispredict_c;

  assign bp.branchCount     = br_cnt_q;
  assign bp.mispredictCount = mis_cnt_q;

  // Tag-free table: PC bits outside the index field are intentionally ignored.
  assign unused_pc_bits = ^{bp.pcF[ADDR_WIDTH-1:INDEX_BITS+2], bp.pcF[1:0],
                            bp.pcE[ADDR_WIDTH-1:INDEX_BITS+2], bp.pcE[1:0]};

  always_comb begin
    table_d   = table_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (update_c) begin
      if (bp.takenE && (table_q[e_idx_c] != CTR_ST)) begin
        table_d[e_idx_c] = table_q[e_idx_c] + 2'd1;
      end else if (!bp.takenE && (table_q[e_idx_c] != CTR_SNT)) begin
        table_d[e_idx_c] = table_q[e_idx_c] - 2'd1;
      end
      if (br_cnt_q != {CNT_WIDTH{1'b1}}) begin
        br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
      end
      if (mispredict_c && (mis_cnt_q != {CNT_WIDTH{1'b1}})) begin
        mis_cnt_d = mis_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      table_q   <= {ENTRIES{CTR_WNT}};
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      table_q   <= table_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the counter table and statistics.
module tb_branch_predict_ctrl;

  localparam int unsigned AW  = 32;
  localparam int unsigned CW  = 16;
  localparam int unsigned IB  = 4;
  localparam int unsigned NE  = 16;
  localparam int unsigned CMAX = 65535;
  localparam logic [6:0]  BR  = 7'b1100011;

  logic clk = 1'b0;
  logic rst;
  logic stall;

  always #5 clk = ~clk;

  branch_predict_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bp ();

  branch_predict_ctrl #(.INDEX_BITS(IB), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .bp    (bp.slave)
  );

  int          m_tbl [NE];
  int unsigned m_br;
  int unsigned m_mis;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  // Model state change at a clock edge given the inputs present at that edge.
  task automatic model_edge(input logic r, input logic s, input logic be, input logic tk,
                            input logic pt, input logic [31:0] pce);
    int i;
    if (r) begin
      foreach (m_tbl[k]) m_tbl[k] = 1;
      m_br  = 0;
      m_mis = 0;
    end else if (be === 1'b1 && !s) begin
      i = idx(pce);
      if (m_br < CMAX) m_br++;
      if (tk != pt && m_mis < CMAX) m_mis++;
      if (tk) m_tbl[i] = (m_tbl[i] == 3) ? 3 : m_tbl[i] + 1;
      else    m_tbl[i] = (m_tbl[i] == 0) ? 0 : m_tbl[i] - 1;
    end
  endtask

  // One cycle: apply inputs, check combinational outputs, clock, check statistics.
  task automatic drive(input string tag, input logic r, input logic s,
                       input logic [31:0] pcf, input logic [6:0] op, input logic [31:0] tgtf,
                       input logic be, input logic tk, input logic pt,
                       input logic [31:0] pce, input logic [31:0] tgte, input logic [31:0] p4e);
    logic        ep;
    logic        mis;
    logic [31:0] epc;
    rst = r;  stall = s;
    bp.pcF = pcf;  bp.opcodeF = op;  bp.pcTargetF = tgtf;
    bp.branchE = be;  bp.takenE = tk;  bp.predTakenE = pt;
    bp.pcE = pce;  bp.pcTargetE = tgte;  bp.pcPlus4E = p4e;
    #2;
    ep  = !r && (op == BR) && (m_tbl[idx(pcf)] >= 2);
    mis = !r && (be === 1'b1) && !s && (tk != pt);
    epc = ep ? tgtf : pcf + 32'd4;
    chk({tag, "/predT"},  64'(bp.predictTakenF), 64'(ep));
    chk({tag, "/predPC"}, 64'(bp.predPCF), 64'(epc));
    chk({tag, "/redir"},  64'(bp.redirectE), 64'(mis));
    chk({tag, "/flushD"}, 64'(bp.flushD), 64'(mis));
    chk({tag, "/flushE"}, 64'(bp.flushE), 64'(mis));
    chk({tag, "/redirPC"}, 64'(bp.redirectPC), 64'(tk ? tgte : p4e));
    @(posedge clk);
    model_edge(r, s, be, tk, pt, pce);
    #1;
    chk({tag, "/brCnt"},  64'(bp.branchCount), 64'(m_br));
    chk({tag, "/misCnt"}, 64'(bp.mispredictCount), 64'(m_mis));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    foreach (m_tbl[k]) m_tbl[k] = 1;
    m_br = 0;
    m_mis = 0;
    rst = 1'b1;
    stall = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset, then a fetch of a branch at 0x40
    drive("rst0", 1, 0, 32'h40, BR, 32'h80, 0, 0, 0, 32'h0, 32'h0, 32'h4);
    drive("t1", 0, 0, 32'h40, BR, 32'h80, 0, 0, 0, 32'h0, 32'h0, 32'h4);
    chk("t1_predT", 64'(bp.predictTakenF), 64'd0);
    chk("t1_predPC", 64'(bp.predPCF), 64'h44);
    chk("t1_cnt", 64'(bp.branchCount), 64'd0);

    // 2: taken branch predicted not-taken
    drive("t2", 0, 0, 32'h40, BR, 32'h80, 1, 1, 0, 32'h40, 32'h80, 32'h44);
    chk("t2_cnt", 64'({bp.branchCount, bp.mispredictCount}), 64'h0001_0001);
    chk("t2_predT_next", 64'(bp.predictTakenF), 64'd1);
    chk("t2_predPC_next", 64'(bp.predPCF), 64'h80);

    // 3: saturate at ST, then a not-taken mispredict
    repeat (4) drive("t3_train", 0, 0, 32'h40, BR, 32'h80, 1, 1, 1, 32'h40, 32'h80, 32'h44);
    drive("t3", 0, 0, 32'h40, BR, 32'h80, 1, 0, 1, 32'h40, 32'h80, 32'h44);
    chk("t3_predT_after", 64'(bp.predictTakenF), 64'd1);

    // 4: stall freezes redirect and statistics, release lets it fire
    drive("t4_stall", 0, 1, 32'h40, BR, 32'h80, 1, 0, 1, 32'h40, 32'h80, 32'h44);
    drive("t4_rel", 0, 0, 32'h40, BR, 32'h80, 1, 0, 1, 32'h40, 32'h80, 32'h44);

    // 5: aliasing and same-cycle read/update without bypass
    drive("t5_train", 0, 0, 32'h40, BR, 32'h80, 1, 1, 1, 32'h40, 32'h80, 32'h44);
    drive("t5_alias", 0, 0, 32'h80, BR, 32'hC0, 0, 0, 0, 32'h0, 32'h0, 32'h4);
    chk("t5_alias_predT", 64'(bp.predictTakenF), 64'd1);
    drive("t5_rw_a", 0, 0, 32'h40, BR, 32'h80, 1, 0, 1, 32'h40, 32'h80, 32'h44);
    drive("t5_rw_b", 0, 0, 32'h40, BR, 32'h80, 1, 0, 1, 32'h40, 32'h80, 32'h44);
    chk("t5_rw_after", 64'(bp.predictTakenF), 64'd0);

    // 6: reset pulse mid-run with an undefined branchE
    drive("t6_rst", 1, 0, 32'h40, BR, 32'h80, 1'bx, 1, 0, 32'h40, 32'h80, 32'h44);
    chk("t6_cnt", 64'({bp.branchCount, bp.mispredictCount}), 64'h0);
    drive("t6_post", 0, 0, 32'h40, BR, 32'h80, 0, 0, 0, 32'h0, 32'h0, 32'h4);

    // Statistics saturation: hold a mispredicting branch for > 2^16 cycles
    drive("sat0", 0, 0, 32'h40, BR, 32'h80, 1, 1, 0, 32'h40, 32'h80, 32'h44);
    repeat (65540) begin
      @(posedge clk);
      model_edge(0, 0, 1, 1, 0, 32'h40);
    end
    #1;
    chk("sat_br", 64'(bp.branchCount), 64'hFFFF);
    chk("sat_mis", 64'(bp.mispredictCount), 64'hFFFF);
    drive("sat1", 0, 0, 32'h40, BR, 32'h80, 1, 1, 0, 32'h40, 32'h80, 32'h44);
    chk("sat_hold", 64'(bp.mispredictCount), 64'hFFFF);

    // Randomized traffic; PCs drawn from a small window to force aliasing
    drive("rnd_rst", 1, 0, 32'h0, 7'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h4);
    for (int n = 0; n < 600; n++) begin
      logic        r, s, be, tk, pt;
      logic [31:0] pcf, pce;
      logic [6:0]  op;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 20);
      be  = $urandom_range(0, 1);
      tk  = $urandom_range(0, 1);
      pt  = $urandom_range(0, 1);
      op  = ($urandom_range(0, 3) != 0) ? BR : 7'($urandom);
      pcf = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0, 6'($urandom), 2'b00};
      pce = {24'($urandom), 6'($urandom), 2'b00};
      drive("rnd", r, s, pcf, op, $urandom, be, tk, pt, pce, $urandom, pce + 32'd4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
